// File: rtl/bubble_plot_ctrl.sv
// Draws 4x4 bubble sprites for each enabled bubble, one pixel per clock, into a VGA adapter.
// Optional macro BUBBLE_CLIP_EN suppresses the write strobe for pixels beyond 159x119.
module bubble_plot_ctrl #(
  parameter logic [2:0] BUB_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR  = 3'b001
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start,
  input  logic        erase,
  input  logic [6:0]  mask,
  input  logic [55:0] bx_flat,
  input  logic [48:0] by_flat,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DRAW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [2:0]  r_idx;
  logic [1:0]  r_dx;
  logic [1:0]  r_dy;
  logic        r_erase;
  logic [6:0]  r_mask;
  logic [55:0] r_bx;
  logic [48:0] r_by;

  logic        w_found;
  logic [2:0]  w_next_idx;
  logic [7:0]  w_cur_x;
  logic [6:0]  w_cur_y;
  logic [8:0]  w_sum_x;
  logic [7:0]  w_sum_y;
  logic        w_draw;
  logic        w_visible;

  // Lowest enabled bubble at or above the current index.
  always_comb begin
    w_found    = 1'b0;
    w_next_idx = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      if (!w_found && r_mask[i] && (3'(i) >= r_idx)) begin
        w_found    = 1'b1;
        w_next_idx = 3'(i);
      end
    end
  end

  always_comb begin
    w_cur_x = '0;
    w_cur_y = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      if (r_idx == 3'(i)) begin
        w_cur_x = r_bx[8*i +: 8];
        w_cur_y = r_by[7*i +: 7];
      end
    end
  end

  assign w_sum_x = {1'b0, w_cur_x} + {7'b0, r_dx};
  assign w_sum_y = {1'b0, w_cur_y} + {6'b0, r_dy};
  assign w_draw  = (r_state == S_DRAW);

`ifdef BUBBLE_CLIP_EN
  assign w_visible = (w_sum_x <= 9'd159) && (w_sum_y <= 8'd119);
`else
  assign w_visible = 1'b1;
`endif

  assign vga_plot   = w_draw && w_visible;
  assign vga_x      = w_draw ? w_sum_x[7:0] : '0;
  assign vga_y      = w_draw ? w_sum_y[6:0] : '0;
  assign vga_colour = w_draw ? (r_erase ? BG_COLOUR : BUB_COLOUR) : '0;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_erase <= 1'b0;
      r_mask  <= '0;
      r_bx    <= '0;
      r_by    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_erase <= erase;
            r_mask  <= mask;
            r_bx    <= bx_flat;
            r_by    <= by_flat;
            r_idx   <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_found) begin
            r_idx   <= w_next_idx;
            r_dx    <= '0;
            r_dy    <= '0;
            r_state <= S_DRAW;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DRAW: begin
          r_dx <= r_dx + 2'd1;
          if (r_dx == 2'd3) begin
            r_dy <= r_dy + 2'd1;
            if (r_dy == 2'd3) begin
              r_idx   <= r_idx + 3'd1;
              r_state <= S_SCAN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_plot_ctrl.sv
// Self-checking bench for bubble_plot_ctrl: per-cycle comparison against a pass-level model.
module tb_bubble_plot_ctrl;

  localparam logic [2:0] TB_BUB = 3'b111;
  localparam logic [2:0] TB_BG  = 3'b001;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic        start;
  logic        erase;
  logic [6:0]  mask;
  logic [55:0] bx_flat;
  logic [48:0] by_flat;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [18:0] exp_vga [0:127];
  int          exp_done;

  bubble_plot_ctrl #(.BUB_COLOUR(TB_BUB), .BG_COLOUR(TB_BG)) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .start      (start),
    .erase      (erase),
    .mask       (mask),
    .bx_flat    (bx_flat),
    .by_flat    (by_flat),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Expected output per cycle after the start edge: bubble n (n-th enabled) scans in
  // cycle 1+17n and draws pixel p in cycle 2+17n+p in raster order.
  task automatic build_model(input logic e, input logic [6:0] m,
                             input logic [55:0] bx, input logic [48:0] by);
    int n;
    n = 0;
    for (int k = 0; k < 128; k++) exp_vga[k] = '0;
    for (int b = 0; b < 7; b++) begin
      if (m[b]) begin
        for (int p = 0; p < 16; p++) begin
          int x;
          int y;
          logic pl;
          x  = int'(bx[8*b +: 8]) + (p % 4);
          y  = int'(by[7*b +: 7]) + (p / 4);
          pl = 1'b1;
`ifdef BUBBLE_CLIP_EN
          pl = (x <= 159) && (y <= 119);
`endif
          exp_vga[2 + 17*n + p] = {pl, 8'(x), 7'(y), (e ? TB_BG : TB_BUB)};
        end
        n++;
      end
    end
    exp_done = 17*n + 2;
  endtask

  task automatic scramble_inputs();
    erase   = 1'($urandom);
    mask    = 7'($urandom);
    bx_flat = 56'({$urandom(), $urandom()});
    by_flat = 49'({$urandom(), $urandom()});
  endtask

  // Runs one pass; inputs are randomised every cycle after the start edge to prove latching,
  // start is re-asserted in cycle mid_start (if >0) and in the DONE cycle, both must be ignored.
  task automatic run_pass(input string name, input logic e, input logic [6:0] m,
                          input logic [55:0] bx, input logic [48:0] by, input int mid_start);
    build_model(e, m, bx, by);
    @(negedge CLOCK_50);
    erase = e; mask = m; bx_flat = bx; by_flat = by; start = 1'b1;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
    for (int k = 1; k <= exp_done + 2; k++) begin
      @(negedge CLOCK_50);
      n_checks++;
      if ({vga_plot, vga_x, vga_y, vga_colour} !== exp_vga[k]) begin
        n_fail++;
        $display("FAIL %s vga cycle %0d: got plot=%b x=%0d y=%0d c=%b, expected plot=%b x=%0d y=%0d c=%b",
                 name, k, vga_plot, vga_x, vga_y, vga_colour,
                 exp_vga[k][18], exp_vga[k][17:10], exp_vga[k][9:3], exp_vga[k][2:0]);
      end
      n_checks++;
      if ({busy, done} !== {(k <= exp_done), (k == exp_done)}) begin
        n_fail++;
        $display("FAIL %s busy/done cycle %0d: got %b%b, expected %b%b (done cycle %0d)",
                 name, k, busy, done, (k <= exp_done), (k == exp_done), exp_done);
      end
      scramble_inputs();
      start = (k == mid_start) || (k == exp_done);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; erase = 1'b0; mask = '0; bx_flat = '0; by_flat = '0;
    repeat (2) @(negedge CLOCK_50);
    start = 1'b1; mask = 7'h7F;
    @(negedge CLOCK_50);
    n_checks++;
    if ({vga_plot, vga_x, vga_y, vga_colour, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {vga_plot, vga_x, vga_y, vga_colour, busy, done});
    end
    start = 1'b0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy got %b, expected 0", busy);
    end
  endtask

  task automatic test_single_bubble();
    logic [55:0] bx;
    logic [48:0] by;
    bx = 56'({$urandom(), $urandom()}); by = 49'({$urandom(), $urandom()});
    bx[7:0] = 8'd10; by[6:0] = 7'd20;
    run_pass("single_bubble", 1'b0, 7'h01, bx, by, 0);
  endtask

  task automatic test_all_erase();
    logic [55:0] bx;
    logic [48:0] by;
    bx = 56'({$urandom(), $urandom()}); by = 49'({$urandom(), $urandom()});
    run_pass("all_erase", 1'b1, 7'h7F, bx, by, 0);
  endtask

  task automatic test_empty_mask();
    run_pass("empty_mask", 1'b0, 7'h00, 56'({$urandom(), $urandom()}),
             49'({$urandom(), $urandom()}), 0);
  endtask

  task automatic test_restart_ignored();
    run_pass("restart_ignored", 1'b0, 7'h44, 56'({$urandom(), $urandom()}),
             49'({$urandom(), $urandom()}), 10);
  endtask

  task automatic test_clip_edge();
    logic [55:0] bx;
    logic [48:0] by;
    bx = 56'({$urandom(), $urandom()}); by = 49'({$urandom(), $urandom()});
    bx[7:0] = 8'd158; by[6:0] = 7'd118;
    run_pass("clip_edge", 1'b0, 7'h01, bx, by, 0);
  endtask

  task automatic test_reset_mid_draw();
    logic [55:0] bx;
    logic [48:0] by;
    bx = 56'({$urandom(), $urandom()}); by = 49'({$urandom(), $urandom()});
    bx[7:0] = 8'd40; by[6:0] = 7'd30;
    build_model(1'b0, 7'h01, bx, by);
    @(negedge CLOCK_50);
    erase = 1'b0; mask = 7'h01; bx_flat = bx; by_flat = by; start = 1'b1;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
    repeat (6) @(negedge CLOCK_50);
    n_checks++;
    if ({vga_plot, vga_x, vga_y, vga_colour} !== exp_vga[6]) begin
      n_fail++;
      $display("FAIL reset_mid_draw_pre: got %b, expected %b",
               {vga_plot, vga_x, vga_y, vga_colour}, exp_vga[6]);
    end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({vga_plot, vga_x, vga_y, vga_colour, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_draw_async: got %b, expected all zero",
               {vga_plot, vga_x, vga_y, vga_colour, busy, done});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50);
      n_checks++;
      if ({vga_plot, busy, done} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_mid_draw_hold: got plot/busy/done %b, expected 000",
                 {vga_plot, busy, done});
      end
    end
    resetn = 1'b1;
    @(negedge CLOCK_50);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_draw_release: got busy/done %b, expected 00", {busy, done});
    end
    run_pass("after_reset", 1'b0, 7'h01, bx, by, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_pass("random", 1'($urandom), 7'($urandom), 56'({$urandom(), $urandom()}),
               49'({$urandom(), $urandom()}), (i % 2 == 0) ? 4 : 0);
    end
  endtask

  task automatic test_back_to_back();
    run_pass("back_to_back_a", 1'b0, 7'h41, 56'({$urandom(), $urandom()}),
             49'({$urandom(), $urandom()}), 0);
    run_pass("back_to_back_b", 1'b1, 7'h41, 56'({$urandom(), $urandom()}),
             49'({$urandom(), $urandom()}), 0);
  endtask

  initial begin
    test_reset();
    test_single_bubble();
    test_all_erase();
    test_empty_mask();
    test_restart_ignored();
    test_clip_edge();
    test_reset_mid_draw();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bubble_plot_ctrl.md
BUBBLE_PLOT_CTRL -- requirements
Module: bubble_plot_ctrl

Interface
REQ-001 Parameter BUB_COLOUR, default 3'b111, colour of a drawn bubble pixel.
REQ-002 Parameter BG_COLOUR, default 3'b001, colour written when erasing.
REQ-003 CLOCK_50  in  1  single clock; all state changes on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  single-cycle request to begin one draw pass.
REQ-006 erase  in  1  pass mode, sampled with start: 1 = erase, 0 = plot.
REQ-007 mask  in  7  bubble enables, sampled with start; bit i selects bubble i.
REQ-008 bx_flat  in  56  bubble X coords, bubble i at [8i+7:8i].
REQ-009 by_flat  in  49  bubble Y coords, bubble i at [7i+6:7i].
REQ-010 vga_x  out  8  pixel X to the VGA adapter.
REQ-011 vga_y  out  7  pixel Y to the VGA adapter.
REQ-012 vga_colour  out  3  pixel colour.
REQ-013 vga_plot  out  1  write strobe; pixel outputs are valid when high.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at end of a pass.

Function
REQ-016 States: IDLE, SCAN, DRAW, DONE; state register only, all outputs decoded from registered state and counters (no added latency).
REQ-017 IDLE with start=1 at an edge: latch erase, mask, bx_flat, by_flat; idx <= 0; next state SCAN.
REQ-018 start while busy is ignored; latched copies stay unchanged for the whole pass.
REQ-019 SCAN (one cycle): if a latched mask bit is set at index >= idx, idx <= lowest such index, dx <= 0, dy <= 0, next DRAW; otherwise next DONE.
REQ-020 DRAW: vga_plot=1, vga_x = X[idx]+dx (8-bit), vga_y = Y[idx]+dy (7-bit), vga_colour = BG_COLOUR if erase else BUB_COLOUR.
REQ-021 Sprite 4x4: dx steps 0..3 every cycle, dy increments when dx wraps 3->0; after pixel (3,3) idx <= idx+1, next SCAN.
REQ-022 Each enabled bubble costs exactly 17 cycles (1 SCAN + 16 DRAW); a pass with N enabled bubbles has done high in cycle 17N+2 after the start edge.
REQ-023 DONE: done=1 for exactly one cycle, next IDLE; a start in DONE is ignored.
REQ-024 Outside DRAW: vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
REQ-025 idx at 6 completing DRAW wraps nothing: idx becomes 7, the next SCAN finds no candidate and goes to DONE.

Reset
REQ-026 resetn low forces, immediately and asynchronously: state IDLE, idx/dx/dy 0, latched registers 0, all outputs 0.
REQ-027 Reset during DRAW aborts the pass; vga_plot falls without waiting for a clock; no done pulse is produced.

Configuration
REQ-028 Macro BUBBLE_CLIP_EN defined: DRAW pixels with X[idx]+dx > 159 or Y[idx]+dy > 119 (computed 9-/8-bit, no wrap) have vga_plot=0; timing unchanged (still 16 cycles).
REQ-029 BUBBLE_CLIP_EN undefined: coordinates wrap modulo 256/128 and every DRAW pixel has vga_plot=1.

Verification
REQ-030 mask=7'h01, X0=10, Y0=20, erase=0, start -> 16 plots (10..13, 20..23) raster order, colour 3'b111, done in cycle 19.
REQ-031 mask=7'h7F, erase=1 -> 112 plots, colour 3'b001, bubbles in index order, done in cycle 121, busy high cycles 1..121.
REQ-032 mask=7'h00, start -> no vga_plot, done in cycle 2, busy high cycles 1..2.
REQ-033 mask=7'h44, start repeated mid-pass with different mask -> only bubbles 2 and 6 drawn, done in cycle 36.
REQ-034 X0=158, Y0=118, mask=7'h01: with BUBBLE_CLIP_EN 4 plots (158..159, 118..119); without it 16 plots, X wrapping is not hit, Y reaching 121 (no Y wrap).
REQ-035 resetn low during 5th DRAW cycle -> outputs 0 at once, no done; new start after release runs a full pass normally.
